tick_timebase: RTL

- Parametrised timebase and event counter for lab designs clocked from CLOCK_50, for example an ADC sample-rate strobe or a seconds display.
- Generates a one-cycle tick every PERIOD clock cycles while enabled.
- Supports periodic or one-shot mode, pause, a run-time loadable period, and a wrapping count of elapsed ticks.
- Sits between the board clock and any consumer FSM that needs slow, strobe-qualified timing.

---
 rtl/tick_timebase.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/tick_timebase.sv
// Strobe timebase: one-cycle tick every PERIOD clocks, with pause,
// one-shot mode, run-time period load and a wrapping tick counter.
module tick_timebase #(
    parameter int DIV_WIDTH      = 26,
    parameter int DEFAULT_PERIOD = 50000000,
    parameter int CNT_WIDTH      = 8,
    parameter int MAX_COUNT      = 60
) (
    input  logic                 CLOCK_50,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic                 pause,
    input  logic                 mode,
    input  logic                 clr,
    input  logic                 period_load,
    input  logic [DIV_WIDTH-1:0] period_in,
    output logic                 tick,
    output logic                 wrap,
    output logic                 done,
    output logic                 busy,
    output logic [CNT_WIDTH-1:0] elapsed
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_RUN    = 2'd1;
    localparam logic [1:0] S_PAUSED = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    localparam logic [DIV_WIDTH-1:0] PERIOD_RST = DIV_WIDTH'(DEFAULT_PERIOD);
    localparam logic [CNT_WIDTH-1:0] CNT_LAST   = CNT_WIDTH'(MAX_COUNT - 1);

    logic [1:0]           state,     state_n;
    logic [DIV_WIDTH-1:0] divider,   divider_n;
    logic [DIV_WIDTH-1:0] period,    period_n;
    logic                 mode_q,    mode_n;
    logic [CNT_WIDTH-1:0] elapsed_q, elapsed_n;
    logic                 tick_n;
    logic                 wrap_n;
    logic                 at_end;

    // Full-width compare; period is never 0 so period-1 cannot underflow.
    assign at_end = (divider == (period - 1'b1));

    always_comb begin
        state_n   = state;
        divider_n = divider;
        period_n  = period;
        mode_n    = mode_q;
        elapsed_n = elapsed_q;
        tick_n    = 1'b0;
        wrap_n    = 1'b0;

        unique case (state)
            S_IDLE: begin
                divider_n = '0;
                if (period_load && (period_in != '0)) begin
                    period_n = period_in;
                end
                if (start) begin
                    state_n = S_RUN;
                    mode_n  = mode;
                end
            end
            S_RUN, S_PAUSED: begin
                if (!start) begin
                    state_n   = S_IDLE;
                    divider_n = '0;
                end else if (pause) begin
                    state_n = S_PAUSED;
                end else begin
                    // The resume edge counts too, so pauses stretch 1:1.
                    state_n = S_RUN;
                    if (at_end) begin
                        divider_n = '0;
                        tick_n    = 1'b1;
                        if (mode_q) begin
                            state_n = S_DONE;
                        end
                    end else begin
                        divider_n = divider + 1'b1;
                    end
                end
            end
            S_DONE: begin
                divider_n = '0;
                if (!start) begin
                    state_n = S_IDLE;
                end
            end
            default: begin
                state_n   = S_IDLE;
                divider_n = '0;
            end
        endcase

        if (tick_n) begin
            if (elapsed_q == CNT_LAST) begin
                elapsed_n = '0;
                wrap_n    = 1'b1;
            end else begin
                elapsed_n = elapsed_q + 1'b1;
            end
        end

        // A suppressed tick must not complete a one-shot run.
        if (clr) begin
            divider_n = '0;
            elapsed_n = '0;
            tick_n    = 1'b0;
            wrap_n    = 1'b0;
            if ((state_n == S_DONE) && (state != S_DONE)) begin
                state_n = S_RUN;
            end
        end
    end

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            divider   <= '0;
            period    <= PERIOD_RST;
            mode_q    <= 1'b0;
            elapsed_q <= '0;
            tick      <= 1'b0;
            wrap      <= 1'b0;
            done      <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_n;
            divider   <= divider_n;
            period    <= period_n;
            mode_q    <= mode_n;
            elapsed_q <= elapsed_n;
            tick      <= tick_n;
            wrap      <= wrap_n;
            done      <= (state_n == S_DONE);
            busy      <= (state_n == S_RUN) || (state_n == S_PAUSED);
        end
    end

    assign elapsed = elapsed_q;

endmodule
